// File: rtl/vmx_systolic_engine.sv
// ---------------------------------------------------------------------------
// vmx_systolic_engine
//
// Weight-stationary systolic matrix-vector engine. A ROWS x COLS weight matrix
// is loaded one row per beat; afterwards each accepted input vector x
// (length ROWS) produces y[c] = sum_r x[r]*W[r][c] (length COLS), wrapped to
// ACC_W bits. With simd_q=1 every PE computes x.hi*W.hi + x.lo*W.lo on signed
// DATA_W/2 halves instead of one full-width product. ACC_W must exceed
// 2*DATA_W.
//
// Dataflow: x[r] enters row r after an r-cycle skew and then moves one column
// right per cycle. Partial sums move one row down per cycle. Column c
// finishes at stage ROWS+c and is delayed by COLS-c more stages, so every
// column of a vector arrives at y_data together, ROWS+COLS+1 advancing cycles
// after the x handshake. The whole pipeline moves in lock-step on adv.
//
// Handshakes (all three streams): a beat transfers on a rising edge where
// valid && ready. The producer holds valid and data until that edge; ready may
// depend on the same cycle's valid only where noted (w_ready looks at x_valid
// so that x wins a tie in RUN).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cfg_simd             PE mode, latched on the first weight beat of a load
//   w_valid/w_ready/w_last/w_data   weight rows, element c at [c*DATA_W +: DATA_W]
//   x_valid/x_ready/x_data          input vectors, element r at [r*DATA_W +: DATA_W]
//   y_valid/y_ready/y_data          results, element c at [c*ACC_W +: ACC_W]
//   weights_valid        a complete weight set is loaded (state RUN)
//   busy                 loading, or any vector in flight
//   err                  sticky load-framing error (early or missing w_last)
//   fsm_state            current controller state (IDLE=0, LOAD=1, RUN=2)
// ---------------------------------------------------------------------------
module vmx_systolic_engine #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_simd,
    input  logic                     w_valid,
    input  logic                     w_last,
    output logic                     w_ready,
    input  logic [DATA_W*COLS-1:0]   w_data,
    input  logic                     x_valid,
    output logic                     x_ready,
    input  logic [DATA_W*ROWS-1:0]   x_data,
    output logic                     y_valid,
    input  logic                     y_ready,
    output logic [ACC_W*COLS-1:0]    y_data,
    output logic                     weights_valid,
    output logic                     busy,
    output logic                     err,
    output logic [1:0]               fsm_state
);

    localparam int L      = ROWS + COLS + 1;
    localparam int RCNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int H      = DATA_W / 2;
    localparam logic [RCNT_W-1:0] LAST_ROW = RCNT_W'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [RCNT_W-1:0]   rcnt;
    logic [RCNT_W-1:0]   rcnt_next;
    logic [RCNT_W-1:0]   beat_row;
    logic                simd_q;
    logic                err_q;
    logic                w_ready_c;
    logic                x_ready_c;
    logic                w_fire;
    logic                x_fire;
    logic                first_beat;
    logic                last_row_beat;
    logic                adv;
    logic                pipe_empty;
    logic [L-1:0]        vld;

    logic [DATA_W-1:0]   w_q [ROWS][COLS];
    // xh[r][c]: operand entering PE(r,c); ps[r][c]: partial sum leaving it.
    logic [DATA_W-1:0]   xh  [ROWS][COLS];
    logic [ACC_W-1:0]    ps  [ROWS][COLS];

    // One PE product, sign-extended to ACC_W.
    function automatic logic [ACC_W-1:0] pe_prod(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic              simd
    );
        logic signed [2*DATA_W-1:0] ae;
        logic signed [2*DATA_W-1:0] be;
        logic signed [2*DATA_W-1:0] full;
        logic signed [DATA_W-1:0]   ahi;
        logic signed [DATA_W-1:0]   bhi;
        logic signed [DATA_W-1:0]   alo;
        logic signed [DATA_W-1:0]   blo;
        logic signed [DATA_W-1:0]   phi;
        logic signed [DATA_W-1:0]   plo;
        logic [ACC_W-1:0]           res;
        ae   = {{DATA_W{a[DATA_W-1]}}, a};
        be   = {{DATA_W{b[DATA_W-1]}}, b};
        full = ae * be;
        ahi  = {{H{a[DATA_W-1]}}, a[DATA_W-1:H]};
        bhi  = {{H{b[DATA_W-1]}}, b[DATA_W-1:H]};
        alo  = {{H{a[H-1]}}, a[H-1:0]};
        blo  = {{H{b[H-1]}}, b[H-1:0]};
        phi  = ahi * bhi;
        plo  = alo * blo;
        if (simd) begin
            res = {{(ACC_W-DATA_W){phi[DATA_W-1]}}, phi}
                + {{(ACC_W-DATA_W){plo[DATA_W-1]}}, plo};
        end else begin
            res = {{(ACC_W-2*DATA_W){full[2*DATA_W-1]}}, full};
        end
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // Controller
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        rcnt_next     = rcnt;
        beat_row      = '0;
        w_ready_c     = 1'b0;
        x_ready_c     = 1'b0;
        adv           = !vld[L-1] || y_ready;
        pipe_empty    = (vld == '0);
        case (state)
            IDLE: w_ready_c = 1'b1;
            LOAD: begin
                w_ready_c = 1'b1;
                beat_row  = rcnt;
            end
            RUN: begin
                x_ready_c = adv;
                // Reloading is only safe with nothing in flight; x wins a tie.
                w_ready_c = pipe_empty && !x_valid;
            end
            default: state_next = IDLE;
        endcase
        w_fire        = w_valid && w_ready_c;
        x_fire        = x_valid && x_ready_c;
        // A beat taken outside LOAD always starts a new matrix at row 0.
        first_beat    = w_fire && (state != LOAD);
        last_row_beat = (beat_row == LAST_ROW);
        if (w_fire) begin
            if (last_row_beat || w_last) begin
                state_next = RUN;
                rcnt_next  = '0;
            end else begin
                state_next = LOAD;
                rcnt_next  = beat_row + RCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt   <= '0;
            err_q  <= 1'b0;
            simd_q <= 1'b0;
        end else begin
            rcnt <= rcnt_next;
            if (first_beat) begin
                simd_q <= cfg_simd;
            end
            // Framing is wrong when w_last disagrees with the final-row position.
            if (w_fire && (last_row_beat != w_last)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Row 0 clears every other row, so a short load leaves the tail at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    w_q[r][c] <= '0;
                end
            end
        end else if (w_fire) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (r == int'(beat_row)) begin
                        w_q[r][c] <= w_data[c*DATA_W +: DATA_W];
                    end else if (first_beat) begin
                        w_q[r][c] <= '0;
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pipeline valid tracking: vld[k] marks a vector k advancing edges past
    // its handshake.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else if (adv) begin
            vld <= {vld[L-2:0], x_fire};
        end
    end

    // -----------------------------------------------------------------------
    // Input skew and PE array
    // -----------------------------------------------------------------------
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        if (gr == 0) begin : g_noskew
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    xh[0][0] <= '0;
                end else if (adv) begin
                    xh[0][0] <= x_data[0 +: DATA_W];
                end
            end
        end else begin : g_skew
            logic [DATA_W-1:0] sk [gr];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < gr; k++) begin
                        sk[k] <= '0;
                    end
                    xh[gr][0] <= '0;
                end else if (adv) begin
                    sk[0] <= x_data[gr*DATA_W +: DATA_W];
                    for (int k = 1; k < gr; k++) begin
                        sk[k] <= sk[k-1];
                    end
                    xh[gr][0] <= sk[gr-1];
                end
            end
        end

        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            if (gc > 0) begin : g_xpass
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        xh[gr][gc] <= '0;
                    end else if (adv) begin
                        xh[gr][gc] <= xh[gr][gc-1];
                    end
                end
            end

            logic [ACC_W-1:0] sum_in;
            if (gr == 0) begin : g_top
                assign sum_in = '0;
            end else begin : g_chain
                assign sum_in = ps[gr-1][gc];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ps[gr][gc] <= '0;
                end else if (adv) begin
                    ps[gr][gc] <= sum_in + pe_prod(xh[gr][gc], w_q[gr][gc], simd_q);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output deskew: column c gets COLS-c more stages; the last stage of each
    // chain is the y_data register, held while stalled.
    // -----------------------------------------------------------------------
    for (genvar gc = 0; gc < COLS; gc++) begin : g_desk
        logic [ACC_W-1:0] dl [COLS-gc];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j < COLS - gc; j++) begin
                    dl[j] <= '0;
                end
            end else if (adv) begin
                dl[0] <= ps[ROWS-1][gc];
                for (int j = 1; j < COLS - gc; j++) begin
                    dl[j] <= dl[j-1];
                end
            end
        end
        assign y_data[gc*ACC_W +: ACC_W] = dl[COLS-gc-1];
    end

    // -----------------------------------------------------------------------
    // Outputs. Ready outputs are gated by rst_n so they drop the instant reset
    // asserts rather than one edge later.
    // -----------------------------------------------------------------------
    assign w_ready       = rst_n && w_ready_c;
    assign x_ready       = rst_n && x_ready_c;
    assign y_valid       = vld[L-1];
    assign weights_valid = (state == RUN);
    assign busy          = (state == LOAD) || !pipe_empty;
    assign err           = err_q;
    assign fsm_state     = state;

endmodule

// File: tb/tb_vmx_systolic_engine.sv
module tb_vmx_systolic_engine;
    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 40;
    localparam int YW     = ACC_W * COLS;
    localparam int LAT    = ROWS + COLS + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic                   cfg_simd;
    logic                   w_valid, w_last, w_ready;
    logic [DATA_W*COLS-1:0] w_data;
    logic                   x_valid, x_ready;
    logic [DATA_W*ROWS-1:0] x_data;
    logic                   y_valid, y_ready;
    logic [YW-1:0]          y_data;
    logic                   weights_valid, busy, err;
    logic [1:0]             fsm_state;

    vmx_systolic_engine #(
        .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_simd(cfg_simd),
        .w_valid(w_valid), .w_last(w_last), .w_ready(w_ready), .w_data(w_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
        .weights_valid(weights_valid), .busy(busy), .err(err),
        .fsm_state(fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [YW-1:0] exp_q[$];
    logic [15:0]   wset [4][4];
    logic [15:0]   tb_w [4][4];
    bit            tb_simd;
    int            hs_cyc, last_y_cyc, first_hs;
    int            n_pop = 0;
    int            y_seen = 0;
    logic [YW-1:0] prev_y;
    bit            prev_stall = 1'b0;

    task automatic check(input string tag, input logic [YW-1:0] got, input logic [YW-1:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Reference: plain signed dot products against the bench's own weights.
    function automatic logic [YW-1:0] model(input logic [DATA_W*ROWS-1:0] xv);
        logic [YW-1:0] res;
        logic [15:0]   xe, we;
        longint        acc, a, b, ah, bh, al, bl;
        res = '0;
        for (int c = 0; c < COLS; c++) begin
            acc = 0;
            for (int r = 0; r < ROWS; r++) begin
                xe = xv[r*16 +: 16];
                we = tb_w[r][c];
                if (tb_simd) begin
                    ah = $signed(xe[15:8]); bh = $signed(we[15:8]);
                    al = $signed(xe[7:0]);  bl = $signed(we[7:0]);
                    acc = acc + ah * bh + al * bl;
                end else begin
                    a = $signed(xe); b = $signed(we);
                    acc = acc + a * b;
                end
            end
            res[c*ACC_W +: ACC_W] = acc[ACC_W-1:0];
        end
        return res;
    endfunction

    function automatic logic [63:0] xpack4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [YW-1:0] ypack4(input int a, input int b, input int c, input int d);
        return {40'(d), 40'(c), 40'(b), 40'(a)};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (y_valid) y_seen++;
            if (prev_stall) check("stall_hold", y_data, prev_y);
            prev_stall = y_valid && !y_ready;
            prev_y     = y_data;
            if (y_valid && y_ready) begin
                if (exp_q.size() == 0) check("y_unexpected", y_valid, 1'b0);
                else begin
                    check("y_data", y_data, exp_q.pop_front());
                    n_pop++;
                    last_y_cyc = cyc;
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- drivers ----------------
    task automatic send_x(input logic [63:0] xv, input logic [YW-1:0] ex);
        bit ok;
        ok = 1'b0;
        x_data  = xv;
        x_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (x_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("x_hs_timeout", x_ready, 1'b1);
        else begin
            exp_q.push_back(ex);
            hs_cyc = cyc;
        end
        @(posedge clk); #1;
    endtask

    task automatic load_w(input int last_at, input bit simd, input bit drop_last);
        bit ok;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                tb_w[r][c] = (r <= last_at) ? wset[r][c] : 16'h0;
        tb_simd  = simd;
        cfg_simd = simd;
        for (int r = 0; r <= last_at; r++) begin
            for (int c = 0; c < COLS; c++) w_data[c*16 +: 16] = wset[r][c];
            w_last  = (r == last_at) && !drop_last;
            w_valid = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (w_ready) begin ok = 1'b1; break; end
            end
            if (!ok) check("w_hs_timeout", w_ready, 1'b1);
            @(posedge clk); #1;
            if (r == 0) begin
                cfg_simd = !simd;  // must be ignored from here on
                if (last_at > 0) begin
                    check("load_busy", busy, 1'b1);
                    check("load_wv_low", weights_valid, 1'b0);
                end
            end
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic rand_w(input bit row3_nonzero);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                wset[r][c] = 16'($urandom_range(0, 65535));
        if (row3_nonzero)
            for (int c = 0; c < COLS; c++) wset[3][c] = wset[3][c] | 16'h0001;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] xv;
        int          pop0;
        rst_n = 1'b1; cfg_simd = 1'b0;
        w_valid = 1'b0; w_last = 1'b0; w_data = '0;
        x_valid = 1'b0; x_data = '0; y_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_w_ready", w_ready, 1'b0);
        check("rst_x_ready", x_ready, 1'b0);
        check("rst_y_valid", y_valid, 1'b0);
        check("rst_y_data", y_data, '0);
        check("rst_wv", weights_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_state", fsm_state, 2'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("w_ready_after_rst", w_ready, 1'b1);
        check("x_ready_idle", x_ready, 1'b0);
        @(posedge clk); #1;

        // Identity weights, latency
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) wset[r][c] = (r == c) ? 16'd1 : 16'd0;
        load_w(3, 1'b0, 1'b0);
        check("ident_err", err, 1'b0);
        check("ident_wv", weights_valid, 1'b1);
        check("ident_state", fsm_state, 2'd2);
        send_x(xpack4(1, 2, 3, 4), ypack4(1, 2, 3, 4));
        x_valid = 1'b0;
        check("inflight_busy", busy, 1'b1);
        check("inflight_w_ready", w_ready, 1'b0);
        wait_drain();
        check("latency", last_y_cyc - hs_cyc, LAT);

        // SIMD halves
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) wset[r][c] = 16'h0102;
        load_w(3, 1'b1, 1'b0);
        send_x({4{16'h0304}}, ypack4(44, 44, 44, 44));
        x_valid = 1'b0;
        wait_drain();

        // Most negative operands
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) wset[r][c] = 16'h8000;
        load_w(3, 1'b0, 1'b0);
        send_x({4{16'h8000}}, {4{40'h0100000000}});
        x_valid = 1'b0;
        wait_drain();

        // Back-to-back with a 3-cycle y stall
        rand_w(1'b0);
        load_w(3, 1'b0, 1'b0);
        pop0 = n_pop;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    xv = {$urandom(), $urandom()};
                    send_x(xv, model(xv));
                    if (i == 0) first_hs = hs_cyc;
                end
                x_valid = 1'b0;
            end
            begin
                int t;
                t = 0;
                while (n_pop < pop0 + 2 && t < 300) begin @(posedge clk); t++; end
                #1 y_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 y_ready = 1'b1;
            end
        join
        wait_drain();
        check("b2b_count", n_pop - pop0, 8);
        check("b2b_last_time", last_y_cyc - first_hs, 7 + LAT + 3);

        // Simultaneous w and x in RUN with empty pipeline: x wins
        w_data  = '1;
        w_valid = 1'b1;
        xv      = xpack4(2, -1, 300, -7);
        x_data  = xv;
        x_valid = 1'b1;
        @(negedge clk);
        check("tie_w_ready", w_ready, 1'b0);
        check("tie_x_ready", x_ready, 1'b1);
        exp_q.push_back(model(xv));
        w_valid = 1'b0;
        @(posedge clk); #1;
        x_valid = 1'b0;
        wait_drain();
        check("tie_wv", weights_valid, 1'b1);

        // Early w_last on row 2
        rand_w(1'b1);
        load_w(2, 1'b0, 1'b0);
        check("early_err", err, 1'b1);
        check("early_wv", weights_valid, 1'b1);
        send_x(xpack4(1, 1, 1, 1), model(xpack4(1, 1, 1, 1)));
        send_x(xpack4(0, 0, 0, 7), '0);
        x_valid = 1'b0;
        wait_drain();

        // Reset with 5 vectors in flight
        rand_w(1'b0);
        load_w(3, 1'b0, 1'b0);
        check("err_sticky", err, 1'b1);
        for (int i = 0; i < 5; i++) begin
            xv = {$urandom(), $urandom()};
            send_x(xv, model(xv));
        end
        rst_n   = 1'b0;
        x_valid = 1'b0;
        #1;
        check("mid_rst_y_valid", y_valid, 1'b0);
        check("mid_rst_y_data", y_data, '0);
        check("mid_rst_w_ready", w_ready, 1'b0);
        check("mid_rst_x_ready", x_ready, 1'b0);
        check("mid_rst_wv", weights_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_err", err, 1'b0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        y_seen = 0;
        @(negedge clk);
        check("rel_w_ready", w_ready, 1'b1);
        check("rel_wv", weights_valid, 1'b0);
        repeat (20) @(negedge clk);
        check("no_y_after_rst", y_seen, 0);
        @(posedge clk); #1;

        // Missing w_last on the final row
        rand_w(1'b0);
        load_w(3, 1'b1, 1'b1);
        check("nolast_err", err, 1'b1);
        check("nolast_wv", weights_valid, 1'b1);
        check("nolast_state", fsm_state, 2'd2);
        xv = {$urandom(), $urandom()};
        send_x(xv, model(xv));
        x_valid = 1'b0;
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vmx_systolic_engine.md
VMX_SYSTOLIC_ENGINE -- requirements
Module: vmx_systolic_engine

Interface
REQ-001 SHALL have parameter ROWS, default 4, meaning array rows and input vector length.
REQ-002 SHALL have parameter COLS, default 4, meaning array columns and output vector length.
REQ-003 SHALL have parameter DATA_W, default 16 (even), meaning signed element width.
REQ-004 SHALL have parameter ACC_W, default 40, meaning signed accumulator/result width.
REQ-005 SHALL have port clk  input  1  meaning the single clock; all state is on its rising edge.
REQ-006 SHALL have port rst_n  input  1  meaning asynchronous, active-low reset.
REQ-007 SHALL have port cfg_simd  input  1  meaning 0 = one DATA_W MAC per PE; 1 = two DATA_W/2 lanes per PE.
REQ-008 SHALL have ports w_valid, w_last (inputs, 1), w_ready (output, 1), and w_data (input, DATA_W*COLS), meaning the weight-row stream; element c is at [c*DATA_W +: DATA_W].
REQ-009 SHALL have ports x_valid (input, 1), x_ready (output, 1), and x_data (input, DATA_W*ROWS), meaning the input-vector stream.
REQ-010 SHALL have ports y_valid (output, 1), y_ready (input, 1), and y_data (output, ACC_W*COLS), meaning the result-vector stream.
REQ-011 SHALL have outputs weights_valid, busy, and err, each 1 bit, meaning weights loaded, work in flight or loading, and sticky load-framing error.

Function
REQ-012 SHALL compute y[c] = sum over r of x[r]*W[r][c], all terms signed, with two's-complement wrap modulo 2^ACC_W.
REQ-013 SHALL, when simd_q=1, form the PE product as x.hi*W.hi + x.lo*W.lo, with hi/lo being signed DATA_W/2 halves.
REQ-014 SHALL latch cfg_simd into simd_q on the first accepted weight beat; cfg_simd changes at other times are ignored.
REQ-015 SHALL have FSM states IDLE (no weights), LOAD (row counter active) and RUN (weights_valid=1).
REQ-016 SHALL assert w_ready only in IDLE, in LOAD, or in RUN with the pipeline empty.
REQ-017 SHALL, in IDLE or RUN, treat an accepted weight beat as row 0, enter LOAD, and drop weights_valid.
REQ-018 SHALL, in LOAD, write each accepted beat to row rcnt and increment rcnt.
REQ-019 SHALL, after the beat with rcnt=ROWS-1, go to RUN and reset rcnt to 0.
REQ-020 SHALL, on an early w_last (rcnt<ROWS-1), set err, zero the unloaded rows, and go to RUN.
REQ-021 SHALL set err when w_last is missing on the row ROWS-1 beat, still entering RUN.
REQ-022 SHALL clear err only on reset.
REQ-023 SHALL advance the pipeline (adv) when !y_valid || y_ready; with adv=0 all pipeline stages hold.
REQ-024 SHALL drive x_ready = (state==RUN) && adv; x_ready is 0 in IDLE and LOAD.
REQ-025 SHALL have latency L = ROWS+COLS+1 advancing cycles from an x handshake to the matching y_valid, with inputs skewed by row and outputs deskewed internally.
REQ-026 SHALL sustain one vector per cycle with y_ready=1, deliver results in order, and never lose or duplicate one.
REQ-027 SHALL hold y_data stable while y_valid && !y_ready.
REQ-028 SHALL assert busy while in LOAD or while any pipeline stage holds a valid vector.
REQ-029 SHALL, on simultaneous w_valid and x_valid in RUN with an empty pipeline, accept only the x beat (w_ready=0 that cycle).

Reset
REQ-030 SHALL, on rst_n low, immediately and asynchronously force x_ready=0, w_ready=0, y_valid=0, y_data=0, weights_valid=0, busy=0, err=0, state=IDLE, rcnt=0, simd_q=0, all weights=0, and all pipeline valids=0.
REQ-031 SHALL discard in-flight vectors on reset mid-operation, with no y_valid after release until new weights and vectors arrive.
REQ-032 SHALL leave w_ready=1 in the first cycle after reset release.

Verification
REQ-033 SHALL be verified (ROWS=COLS=4, DATA_W=16, ACC_W=40) as follows: identity W, simd=0, x=(1,2,3,4), y_ready=1 -> y=(1,2,3,4), y_valid exactly 9 cycles after the x handshake.
REQ-034 SHALL be verified as follows: simd=1, all W=0x0102, all x=0x0304 -> every y[c]=44 (3*1+4*2 per PE, times 4 rows).
REQ-035 SHALL be verified as follows: all W=0x8000 and all x=0x8000 -> every y[c]=0x0100000000.
REQ-036 SHALL be verified as follows: 8 back-to-back vectors, y_ready low for 3 cycles mid-stream -> 8 results in order, y_data stable while stalled, last result 3 cycles late.
REQ-037 SHALL be verified as follows: w_last on the row-2 beat -> err=1, weights_valid=1, row 3 reads zero, x=(1,1,1,1) yields the sum of rows 0-2 only.
REQ-038 SHALL be verified as follows: rst_n low with 5 vectors in flight -> all outputs 0 at once, weights_valid=0, no y_valid after release.
